// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle main control FSM: opcodes, state
// encoding, datapath mux encodings and ALU mode values.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned SRCB_W  = 2;
    localparam int unsigned PCSRC_W = 2;
    localparam int unsigned ALUOP_W = 2;

    // Opcode field values of the supported instructions
    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_J     = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd5;
    localparam logic [OP_W-1:0] OP_BEQI  = 6'd6;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OP_W-1:0] OP_SUBI  = 6'd9;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEXEC,
        S_RTWB,
        S_ITEXEC,
        S_ITWB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_e;

    // ALU B operand select
    typedef enum logic [SRCB_W-1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_e;

    // Next-PC select
    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    // {aluop1, aluop2} modes for the ALU control decoder
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 2'b10;

endpackage

// File: rtl/mc_control.sv
// Multicycle main control FSM. Sequences each instruction through
// fetch/decode/execute/memory/writeback and drives datapath controls.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   op                  : IR opcode field (read from DECODE onwards)
//   zero, neg           : ALU flags of the current cycle
//   mem_ready           : memory completes the current access this cycle
//   pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alusrca, alusrcb, pcsrc : datapath controls
//   aluop1, aluop2      : ALU mode (00 add, 01 sub, 10 R-type)
//   illegal_op          : sticky trap indicator, cleared only by reset
module mc_control
    import mc_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     op,
    input  logic                zero,
    input  logic                neg,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alusrca,
    output logic [SRCB_W-1:0]   alusrcb,
    output logic [PCSRC_W-1:0]  pcsrc,
    output logic                aluop1,
    output logic                aluop2,
    output logic                illegal_op
);

    state_e state_q, state_d;

    // State register; reset restarts at FETCH, which also clears the trap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs; everything is held at 0 during reset
    always_comb begin
        state_d          = state_q;
        pc_en            = 1'b0;
        iord             = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        reg_dst          = 1'b0;
        mem_to_reg       = 1'b0;
        reg_write        = 1'b0;
        alusrca          = 1'b0;
        alusrcb          = SRCB_REG;
        pcsrc            = PCSRC_ALU;
        {aluop1, aluop2} = ALU_ADD;
        illegal_op       = 1'b0;

        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    alusrcb  = SRCB_FOUR;
                    // PC+4 and IR load only on the cycle the read completes
                    ir_write = mem_ready;
                    pc_en    = mem_ready;
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Precompute the branch target into ALUOut
                    alusrcb = SRCB_IMM_SH2;
                    case (op)
                        OP_LW, OP_SW:              state_d = S_MEMADR;
                        OP_RTYPE:                  state_d = S_RTEXEC;
                        OP_ADDI, OP_SUBI:          state_d = S_ITEXEC;
                        OP_BEQ, OP_BLT, OP_BEQI:   state_d = S_BRANCH;
                        OP_J:                      state_d = S_JUMP;
                        default:                   state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                    state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_RTEXEC: begin
                    alusrca          = 1'b1;
                    alusrcb          = SRCB_REG;
                    {aluop1, aluop2} = ALU_RTYPE;
                    state_d          = S_RTWB;
                end
                S_RTWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_ITEXEC: begin
                    alusrca          = 1'b1;
                    alusrcb          = SRCB_IMM;
                    {aluop1, aluop2} = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
                    state_d          = S_ITWB;
                end
                S_ITWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    // Compare via subtraction; target was staged in ALUOut
                    alusrca          = 1'b1;
                    alusrcb          = (op == OP_BEQI) ? SRCB_IMM : SRCB_REG;
                    {aluop1, aluop2} = ALU_SUB;
                    pcsrc            = PCSRC_ALUOUT;
                    pc_en            = (op == OP_BLT) ? neg : zero;
                    state_d          = S_FETCH;
                end
                S_JUMP: begin
                    pcsrc   = PCSRC_JUMP;
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end
                S_TRAP: begin
                    illegal_op = 1'b1;
                end
                default: begin
                    state_d = S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a directed vector table, hand-built
// corner sequences and random instruction streams from an instruction-level
// reference model, all checked cycle by cycle.
module tb_mc_control;

    typedef logic [15:0] ovec_t;
    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic        zero;
        logic        neg;
        logic        mready;
        ovec_t       exp;
        logic [63:0] tag;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       neg;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alusrca, aluop1, aluop2, illegal_op;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    ovec_t      dut_vec;

    vec_t       q[$];
    vec_t       dir_tab[12];
    int         n_vec;
    int         n_err;
    logic [5:0] legal_ops[9];

    mc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .neg        (neg),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop1     (aluop1),
        .aluop2     (aluop2),
        .illegal_op (illegal_op)
    );

    assign dut_vec = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_write, alusrca, alusrcb, pcsrc,
                      aluop1, aluop2, illegal_op};

    always #5 clk = ~clk;

    function automatic ovec_t ov(input bit pcen, input bit io, input bit mrd,
                                 input bit mwr, input bit irw, input bit rdst,
                                 input bit m2r, input bit rw, input bit asa,
                                 input bit [1:0] asb, input bit [1:0] pcs,
                                 input bit [1:0] aop, input bit ill);
        return {pcen, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, pcs, aop, ill};
    endfunction

    // Expected output word for each phase of an instruction
    function automatic ovec_t e_fetch(input bit done);
        return ov(done, 0, 1, 0, done, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    endfunction
    function automatic ovec_t e_decode();
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    endfunction
    function automatic ovec_t e_memadr();
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    endfunction
    function automatic ovec_t e_memrd();
        return ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic ovec_t e_memwb();
        return ov(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic ovec_t e_memwr();
        return ov(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic ovec_t e_rtexec();
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0);
    endfunction
    function automatic ovec_t e_wb(input bit rd);
        return ov(0, 0, 0, 0, 0, rd, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction

    function automatic vec_t rec(input bit r, input logic [5:0] o, input bit z,
                                 input bit n, input bit mr, input ovec_t e,
                                 input logic [63:0] t);
        vec_t v;
        v.rst_n  = r;
        v.op     = o;
        v.zero   = z;
        v.neg    = n;
        v.mready = mr;
        v.exp    = e;
        v.tag    = t;
        return v;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input bit r, input logic [5:0] o, input bit z,
                                 input bit n, input bit mr, input ovec_t e,
                                 input logic [63:0] t);
        q.push_back(rec(r, o, z, n, mr, e, t));
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        foreach (legal_ops[i]) begin
            if (legal_ops[i] == o) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference model: expand one instruction into its per-cycle vectors.
    // fw / mw are wait cycles in the fetch and data-memory accesses; z / n
    // are the ALU flags seen in the branch compare cycle.
    function automatic void gen_instr(input logic [5:0] o, input int fw,
                                      input int mw, input bit z, input bit n);
        for (int i = 0; i < fw; i++)
            push(1, 6'($urandom), rb(), rb(), 0, e_fetch(0), "fetchw");
        push(1, 6'($urandom), rb(), rb(), 1, e_fetch(1), "fetch");
        push(1, o, rb(), rb(), rb(), e_decode(), "decode");
        case (o)
            6'd35: begin
                push(1, o, rb(), rb(), rb(), e_memadr(), "lwadr");
                for (int i = 0; i < mw; i++)
                    push(1, o, rb(), rb(), 0, e_memrd(), "lwwait");
                push(1, o, rb(), rb(), 1, e_memrd(), "lwrd");
                push(1, o, rb(), rb(), rb(), e_memwb(), "lwwb");
            end
            6'd43: begin
                push(1, o, rb(), rb(), rb(), e_memadr(), "swadr");
                for (int i = 0; i < mw; i++)
                    push(1, o, rb(), rb(), 0, e_memwr(), "swwait");
                push(1, o, rb(), rb(), 1, e_memwr(), "swwr");
            end
            6'd0: begin
                push(1, o, rb(), rb(), rb(), e_rtexec(), "rtexec");
                push(1, o, rb(), rb(), rb(), e_wb(1), "rtwb");
            end
            6'd8, 6'd9: begin
                push(1, o, rb(), rb(), rb(),
                     ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00,
                        (o == 6'd9) ? 2'b01 : 2'b00, 0), "itexec");
                push(1, o, rb(), rb(), rb(), e_wb(0), "itwb");
            end
            6'd4, 6'd5, 6'd6: begin
                push(1, o, z, n, rb(),
                     ov((o == 6'd5) ? n : z, 0, 0, 0, 0, 0, 0, 0, 1,
                        (o == 6'd6) ? 2'b10 : 2'b00, 2'b01, 2'b01, 0), "branch");
            end
            6'd2: begin
                push(1, o, rb(), rb(), rb(),
                     ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0), "jump");
            end
            default: begin
                // Trap holds until reset; leave with a one-cycle reset
                for (int i = 0; i < 3; i++)
                    push(1, 6'($urandom), rb(), rb(), rb(),
                         ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1), "trap");
                push(0, 6'($urandom), rb(), rb(), rb(), 16'h0, "trapclr");
            end
        endcase
    endfunction

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        op        = 6'd0;
        zero      = 1'b0;
        neg       = 1'b0;
        mem_ready = 1'b0;
        n_vec     = 0;
        n_err     = 0;
        legal_ops = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd35, 6'd43};

        // Directed table: reset, zero-wait R-type, lw with two MEMRD waits
        dir_tab[0]  = rec(0, 6'd0,  0, 0, 0, 16'h0,      "reset");
        dir_tab[1]  = rec(1, 6'd0,  0, 0, 1, e_fetch(1), "rfetch");
        dir_tab[2]  = rec(1, 6'd0,  0, 0, 1, e_decode(), "rdecode");
        dir_tab[3]  = rec(1, 6'd0,  1, 1, 0, e_rtexec(), "rtexec");
        dir_tab[4]  = rec(1, 6'd0,  0, 0, 0, e_wb(1),    "rtwb");
        dir_tab[5]  = rec(1, 6'd0,  0, 0, 1, e_fetch(1), "lfetch");
        dir_tab[6]  = rec(1, 6'd35, 0, 0, 0, e_decode(), "ldecode");
        dir_tab[7]  = rec(1, 6'd35, 0, 0, 1, e_memadr(), "lwadr");
        dir_tab[8]  = rec(1, 6'd35, 0, 0, 0, e_memrd(),  "lwwait");
        dir_tab[9]  = rec(1, 6'd35, 0, 0, 0, e_memrd(),  "lwwait");
        dir_tab[10] = rec(1, 6'd35, 0, 0, 1, e_memrd(),  "lwrd");
        dir_tab[11] = rec(1, 6'd35, 0, 0, 0, e_memwb(),  "lwwb");
        foreach (dir_tab[i]) q.push_back(dir_tab[i]);

        // Branch flags chosen so that using the wrong flag is visible
        gen_instr(6'd4, 0, 0, 1, 0);
        gen_instr(6'd5, 0, 0, 1, 0);
        gen_instr(6'd5, 1, 0, 0, 1);
        gen_instr(6'd9, 0, 0, 0, 0);
        gen_instr(6'd6, 0, 0, 0, 1);
        gen_instr(6'd8, 2, 0, 0, 0);
        gen_instr(6'd2, 0, 0, 0, 0);
        gen_instr(6'd43, 0, 3, 0, 0);
        gen_instr(6'd63, 0, 0, 0, 0);

        // Reset during a MEMWR wait: the store is abandoned, fetch restarts
        push(1, 6'd0,  0, 0, 1, e_fetch(1), "wfetch");
        push(1, 6'd43, 0, 0, 0, e_decode(), "wdecode");
        push(1, 6'd43, 0, 0, 0, e_memadr(), "swadr");
        push(1, 6'd43, 0, 0, 0, e_memwr(),  "swwait");
        push(0, 6'd43, 1, 1, 1, 16'h0,      "rstwr");
        gen_instr(6'd0, 0, 0, 0, 0);

        // Reset during a fetch wait
        push(1, 6'd0, 0, 0, 0, e_fetch(0), "fetchw");
        push(0, 6'd0, 0, 0, 1, 16'h0,      "rstfet");

        // Random instruction stream
        for (int k = 0; k < 250; k++) begin
            logic [5:0] o;
            if ($urandom_range(0, 99) < 90) begin
                o = legal_ops[$urandom_range(0, 8)];
            end else begin
                o = 6'($urandom);
                while (is_legal(o)) o = 6'($urandom);
            end
            gen_instr(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      rb(), rb());
        end

        // Apply each vector after the edge, check at the falling edge
        foreach (q[k]) begin
            @(posedge clk);
            #1;
            rst_n     = q[k].rst_n;
            op        = q[k].op;
            zero      = q[k].zero;
            neg       = q[k].neg;
            mem_ready = q[k].mready;
            @(negedge clk);
            n_vec++;
            if (dut_vec !== q[k].exp) begin
                n_err++;
                $display("FAIL %0s vec %0d op=%0d: got %b, expected %b",
                         q[k].tag, k, q[k].op, dut_vec, q[k].exp);
            end
        end

        // Reset-state check: all outputs forced low while rst_n is low
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        op        = 6'd0;
        zero      = 1'b1;
        neg       = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dut_vec !== 16'h0) begin
            n_err++;
            $display("FAIL reset-state: got %b, expected %b", dut_vec, 16'h0);
        end

        // First active cycle: fetch strobe held while memory is not ready
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dut_vec !== e_fetch(0)) begin
            n_err++;
            $display("FAIL fetch-wait: got %b, expected %b", dut_vec, e_fetch(0));
        end

        // Expired wait: fetch completes with pc_en and ir_write
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dut_vec !== e_fetch(1)) begin
            n_err++;
            $display("FAIL wait-expired: got %b, expected %b", dut_vec, e_fetch(1));
        end

        // Exactly one extra cycle: decode follows the completed fetch
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dut_vec !== e_decode()) begin
            n_err++;
            $display("FAIL post-wait decode: got %b, expected %b", dut_vec, e_decode());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control FSM for the custom MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath muxes, enables and memory strobes, and produces the 2-bit `{aluop1, aluop2}` mode consumed by the ALU control decoder. It sits directly upstream of the ALU control decoder and takes ALU flags and a memory-ready handshake back from the datapath.

## Interface
Parameters: none. Opcodes are fixed constants in the shared package.
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `op` in 6: opcode field of the instruction register (IR)
- `zero` in 1: ALU result == 0, current cycle
- `neg` in 1: ALU result bit 31, current cycle
- `mem_ready` in 1: memory completes the current read/write this cycle
- `pc_en` out 1: PC register load
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write` out 1 each: memory strobes
- `ir_write` out 1: IR load
- `reg_dst` out 1: write-register select; 0 = rt, 1 = rd
- `mem_to_reg` out 1: write-data select; 0 = ALUOut, 1 = MDR
- `reg_write` out 1: register-file write
- `alusrca` out 1: ALU A select; 0 = PC, 1 = register A
- `alusrcb` out 2: ALU B select; 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- `pcsrc` out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target
- `aluop1`, `aluop2` out 1 each: ALU mode; 00 = add, 01 = sub, 10 = R-type/funct. 11 is never driven.
- `illegal_op` out 1: sticky trap indicator

## Operation
- Opcodes: R-type 0, j 2, beq 4, blt 5, beqi 6, addi 8, subi 9, lw 35, sw 43. All others are illegal.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, ITEXEC, ITWB, BRANCH, JUMP, TRAP.
- Every output not listed for a state is 0.
- FETCH: `iord`=0, `mem_read`=1, `alusrca`=0, `alusrcb`=01, aluop=00, `pcsrc`=00.
  - `ir_write` and `pc_en` equal `mem_ready` (Mealy).
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alusrca`=0, `alusrcb`=11, aluop=00 (branch target to ALUOut). Next state:
  - lw/sw → MEMADR
  - R-type → RTEXEC
  - addi/subi → ITEXEC
  - beq/blt/beqi → BRANCH
  - j → JUMP
  - else → TRAP
- MEMADR: `alusrca`=1, `alusrcb`=10, aluop=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_read`=1. Hold until `mem_ready`, then → MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. → FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Hold until `mem_ready`, then → FETCH.
- RTEXEC: `alusrca`=1, `alusrcb`=00, aluop=10. → RTWB.
- RTWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. → FETCH.
- ITEXEC: `alusrca`=1, `alusrcb`=10. aluop=00 for addi, 01 for subi. → ITWB.
- ITWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. → FETCH.
- BRANCH: `alusrca`=1, aluop=01, `pcsrc`=01. → FETCH.
  - `alusrcb`=00 for beq/blt, 10 for beqi.
  - `pc_en` = `zero` for beq/beqi, `neg` for blt (Mealy).
- JUMP: `pcsrc`=10, `pc_en`=1. → FETCH.
- TRAP: `illegal_op`=1, all other outputs 0. Stays in TRAP until reset.
- `op` is read in DECODE and later states only. The IR is stable after FETCH completes.

## Timing
- Reset:
  - While `rst_n`=0, all outputs are forced to 0 combinationally.
  - On the clock edge, the state loads FETCH and the trap flag clears.
  - The first fetch strobe appears in the first cycle with `rst_n`=1.
- Reset mid-instruction, including during a memory wait: the state is abandoned at that edge. No `reg_write` or `pc_en` is emitted during reset.
- Cycles with zero-wait memory (`mem_ready` high in the first cycle):
  - lw 5
  - sw, R-type, addi, subi 4
  - branch, j 3
  - Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Memory strobes stay asserted and `iord` stays stable for the whole wait.
- `pc_en` and `ir_write` pulse for exactly one cycle per fetch.
- `reg_write` is asserted for exactly one cycle per writing instruction.

## Structure
- Package `mc_ctrl_pkg` holds:
  - opcode localparams
  - state enum
  - `alusrcb` and `pcsrc` encodings
  - ALU mode constants: ADD=2'b00, SUB=2'b01, RTYPE=2'b10
- Implementation is a single module: registered state plus one combinational output/next-state block. No sub-module.

## Test plan
- Reset, then R-type (`op`=0) with `mem_ready`=1 → cycles: FETCH (`pc_en`=`ir_write`=1), DECODE, RTEXEC (aluop=10), RTWB (`reg_write`=1, `reg_dst`=1). Fetch restarts at cycle 5.
- lw with `mem_ready` low for 2 cycles in MEMRD → `mem_read`=`iord`=1 held 3 cycles. MEMWB `reg_write`=1 with `mem_to_reg`=1. Total 7 cycles.
- beq with `zero`=1, then blt with `neg`=0 → BRANCH aluop=01 and `pcsrc`=01 in both. `pc_en`=1 for beq, 0 for blt.
- subi then beqi → ITEXEC aluop=01 with `alusrcb`=10. beqi BRANCH uses `alusrcb`=10.
- Opcode 63 → TRAP: `illegal_op`=1 held, all other outputs 0. `rst_n`=0 for 1 cycle → FETCH and `illegal_op`=0.
- `rst_n` pulled low during a MEMWR wait → no `mem_write` in the reset cycle. Next active cycle is FETCH.
